ascon_ctrl_fsm: RTL and testbench

- Control sequencer for the ASCON-128 permutation datapath.
- Drives the datapath control inputs: state mux select, state-register enable, round index, the four XOR enables, and the cipher and tag capture enables.
- Runs the full encryption sequence: initialisation, associated-data absorption, plaintext encryption, finalisation and tag capture.
- Exchanges a valid/ready handshake with the block feeder and flags to the consumer when cipher and tag are valid.

---
 rtl/ascon_pack.sv | 20 ++
 rtl/ascon_ctrl_fsm_if.sv | 37 +++
 rtl/round_counter.sv | 27 ++
 rtl/ascon_ctrl_fsm.sv | 180 ++++++++++++++++++
 tb/tb_ascon_ctrl_fsm.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ascon_pack.sv
// Shared types and constants for the ASCON-128 control sequencer.
package ascon_pack;

    localparam int unsigned NB_ROUNDS_A   = 12;
    localparam logic [3:0]  ROUND_START_B = 4'd6;
    localparam logic [3:0]  ROUND_LAST    = 4'(NB_ROUNDS_A - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_WAIT_AD,
        ST_AD,
        ST_WAIT_PT,
        ST_PT,
        ST_FINAL,
        ST_TAG,
        ST_DONE
    } type_fsm_ctrl;

endpackage

// File: rtl/ascon_ctrl_fsm_if.sv
// Feeder handshake plus datapath control bundle of the ASCON sequencer.
interface ascon_ctrl_fsm_if;

    logic       start_i;
    logic       data_valid_i;
    logic       data_ready_o;
    logic       sel_o;
    logic       en_o;
    logic [3:0] round_o;
    logic       en_xor_data_o;
    logic       en_xor_key_o;
    logic       en_xor_key_final_o;
    logic       en_xor_lsb_o;
    logic       en_out_cipher_o;
    logic       en_out_tag_o;
    logic       cipher_valid_o;
    logic       tag_valid_o;
    logic       busy_o;
    logic       done_o;

    modport master (
        input  start_i, data_valid_i,
        output data_ready_o, sel_o, en_o, round_o,
               en_xor_data_o, en_xor_key_o, en_xor_key_final_o, en_xor_lsb_o,
               en_out_cipher_o, en_out_tag_o, cipher_valid_o, tag_valid_o,
               busy_o, done_o
    );

    modport slave (
        output start_i, data_valid_i,
        input  data_ready_o, sel_o, en_o, round_o,
               en_xor_data_o, en_xor_key_o, en_xor_key_final_o, en_xor_lsb_o,
               en_out_cipher_o, en_out_tag_o, cipher_valid_o, tag_valid_o,
               busy_o, done_o
    );

endinterface

// File: rtl/round_counter.sv
// Permutation round index: loadable 4-bit up-counter that parks at the last round.
module round_counter
    import ascon_pack::*;
(
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic [3:0] cnt,
    output logic       last
);

    assign last = (cnt == ROUND_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && !last) begin
            cnt <= cnt + 4'd1;
        end
    end

endmodule

// File: rtl/ascon_ctrl_fsm.sv
// ASCON-128 encryption sequencer: init, AD absorb, PT encrypt, finalise, tag capture.
module ascon_ctrl_fsm
    import ascon_pack::*;
#(
    parameter int unsigned NB_AD_G = 1,
    parameter int unsigned NB_PT_G = 3
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    ascon_ctrl_fsm_if.master bus
);

    if (NB_AD_G == 0 || NB_AD_G > 15) begin : g_bad_nb_ad
        $error("NB_AD_G must lie in 1..15");
    end
    if (NB_PT_G == 0 || NB_PT_G > 15) begin : g_bad_nb_pt
        $error("NB_PT_G must lie in 1..15");
    end

    localparam logic [3:0] LAST_AD = 4'(NB_AD_G - 1);
    localparam logic [3:0] LAST_PT = 4'(NB_PT_G - 1);
    // A single PT block is also the last one, which runs the full 12 rounds.
    localparam logic [3:0] PT_FIRST_ROUND = (NB_PT_G == 1) ? 4'd0 : ROUND_START_B;

    type_fsm_ctrl state;
    logic [3:0]   blk_cnt;
    logic [3:0]   round_cnt;
    logic [3:0]   cnt_load_val;
    logic         cnt_load;
    logic         round_last;
    logic         xfer;

    assign xfer       = bus.data_valid_i && ((state == ST_WAIT_AD) || (state == ST_WAIT_PT));
    assign bus.round_o = round_cnt;

    round_counter u_round_counter (
        .clock_i  (clock_i),
        .resetb_i (resetb_i),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (bus.en_o),
        .cnt      (round_cnt),
        .last     (round_last)
    );

    // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
    always_comb begin
        bus.data_ready_o       = 1'b0;
        bus.en_o               = 1'b0;
        bus.en_xor_data_o      = 1'b0;
        bus.en_xor_key_o       = 1'b0;
        bus.en_xor_key_final_o = 1'b0;
        bus.en_xor_lsb_o       = 1'b0;
        bus.en_out_cipher_o    = 1'b0;
        bus.en_out_tag_o       = 1'b0;
        bus.done_o             = 1'b0;
        bus.busy_o             = (state != ST_IDLE);
        bus.sel_o              = (state != ST_IDLE);
        cnt_load               = 1'b0;
        cnt_load_val           = '0;

        unique case (state)
            ST_IDLE: begin
                cnt_load = bus.start_i;
            end
            ST_INIT: begin
                bus.en_o  = 1'b1;
                bus.sel_o = (round_cnt != 4'd0);
                if (round_last) begin
                    bus.en_xor_key_final_o = 1'b1;
                    cnt_load               = 1'b1;
                    cnt_load_val           = ROUND_START_B;
                end
            end
            ST_WAIT_AD: begin
                bus.data_ready_o  = 1'b1;
                bus.en_o          = xfer;
                bus.en_xor_data_o = xfer;
            end
            ST_AD: begin
                bus.en_o = 1'b1;
                if (round_last) begin
                    cnt_load = 1'b1;
                    if (blk_cnt == LAST_AD) begin
                        bus.en_xor_lsb_o = 1'b1;
                        cnt_load_val     = PT_FIRST_ROUND;
                    end else begin
                        cnt_load_val = ROUND_START_B;
                    end
                end
            end
            ST_WAIT_PT: begin
                bus.data_ready_o    = 1'b1;
                bus.en_o            = xfer;
                bus.en_xor_data_o   = xfer;
                bus.en_out_cipher_o = xfer;
                bus.en_xor_key_o    = xfer && (blk_cnt == LAST_PT);
            end
            ST_PT: begin
                bus.en_o = 1'b1;
                if (round_last) begin
                    // The round counter is preloaded for the block that follows.
                    cnt_load     = 1'b1;
                    cnt_load_val = (blk_cnt + 4'd1 == LAST_PT) ? 4'd0 : ROUND_START_B;
                end
            end
            ST_FINAL: begin
                bus.en_o               = 1'b1;
                bus.en_xor_key_final_o = round_last;
            end
            ST_TAG: begin
                bus.en_out_tag_o = 1'b1;
            end
            ST_DONE: begin
                bus.done_o = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state              <= ST_IDLE;
            blk_cnt            <= '0;
            bus.cipher_valid_o <= 1'b0;
            bus.tag_valid_o    <= 1'b0;
        end else begin
            bus.cipher_valid_o <= bus.en_out_cipher_o;
            unique case (state)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        state           <= ST_INIT;
                        bus.tag_valid_o <= 1'b0;
                    end
                end
                ST_INIT: begin
                    if (round_last) begin
                        state   <= ST_WAIT_AD;
                        blk_cnt <= '0;
                    end
                end
                ST_WAIT_AD: begin
                    if (xfer) state <= ST_AD;
                end
                ST_AD: begin
                    if (round_last) begin
                        if (blk_cnt == LAST_AD) begin
                            state   <= ST_WAIT_PT;
                            blk_cnt <= '0;
                        end else begin
                            state   <= ST_WAIT_AD;
                            blk_cnt <= blk_cnt + 4'd1;
                        end
                    end
                end
                ST_WAIT_PT: begin
                    if (xfer) state <= (blk_cnt == LAST_PT) ? ST_FINAL : ST_PT;
                end
                ST_PT: begin
                    if (round_last) begin
                        state   <= ST_WAIT_PT;
                        blk_cnt <= blk_cnt + 4'd1;
                    end
                end
                ST_FINAL: begin
                    if (round_last) state <= ST_TAG;
                end
                ST_TAG: begin
                    state           <= ST_DONE;
                    bus.tag_valid_o <= 1'b1;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Bench for ascon_ctrl_fsm: per-cycle expectations built from the operation's block/round schedule.
module tb_ascon_ctrl_fsm;

    typedef struct packed {
        logic       ready;
        logic       en;
        logic       sel;
        logic [3:0] round;
        logic       xd;
        logic       xk;
        logic       xkf;
        logic       xl;
        logic       oc;
        logic       ot;
        logic       cv;
        logic       tv;
        logic       busy;
        logic       done;
    } rec_t;

    logic clk = 1'b0;
    logic resetb;
    always #5 clk = ~clk;

    ascon_ctrl_fsm_if ifc0 ();
    ascon_ctrl_fsm_if ifc1 ();

    ascon_ctrl_fsm #(.NB_AD_G(1), .NB_PT_G(3)) dut0 (.clock_i(clk), .resetb_i(resetb), .bus(ifc0));
    ascon_ctrl_fsm #(.NB_AD_G(2), .NB_PT_G(1)) dut1 (.clock_i(clk), .resetb_i(resetb), .bus(ifc1));

    rec_t obs0, obs1;
    assign obs0 = {ifc0.data_ready_o, ifc0.en_o, ifc0.sel_o, ifc0.round_o, ifc0.en_xor_data_o,
                   ifc0.en_xor_key_o, ifc0.en_xor_key_final_o, ifc0.en_xor_lsb_o, ifc0.en_out_cipher_o,
                   ifc0.en_out_tag_o, ifc0.cipher_valid_o, ifc0.tag_valid_o, ifc0.busy_o, ifc0.done_o};
    assign obs1 = {ifc1.data_ready_o, ifc1.en_o, ifc1.sel_o, ifc1.round_o, ifc1.en_xor_data_o,
                   ifc1.en_xor_key_o, ifc1.en_xor_key_final_o, ifc1.en_xor_lsb_o, ifc1.en_out_cipher_o,
                   ifc1.en_out_tag_o, ifc1.cipher_valid_o, ifc1.tag_valid_o, ifc1.busy_o, ifc1.done_o};

    int n_tests = 0;
    int n_fail  = 0;

    rec_t exp_q[$];
    rec_t msk_q[$];
    rec_t obs_q[$];
    bit   vld_q[$];
    bit   st_q[$];
    bit   cfg_noise;
    bit   cfg_all_valid;
    bit   tv_state[2];

    task automatic drive(int which, logic s, logic v);
        if (which == 0) begin
            ifc0.start_i = s; ifc0.data_valid_i = v;
        end else begin
            ifc1.start_i = s; ifc1.data_valid_i = v;
        end
    endtask

    function automatic bit free_valid();
        return cfg_all_valid ? 1'b1 : (cfg_noise ? 1'($urandom_range(0, 1)) : 1'b0);
    endfunction

    function automatic bit busy_start();
        return cfg_noise ? 1'($urandom_range(0, 1)) : 1'b0;
    endfunction

    task automatic push(rec_t e, bit dc, bit v, bit s);
        rec_t m = '1;
        if (dc) begin
            m.sel = 1'b0; m.round = '0;
        end
        exp_q.push_back(e); msk_q.push_back(m);
        vld_q.push_back(v); st_q.push_back(s);
    endtask

    // One data block: feeder stall, transfer cycle, then the remaining rounds up to 11.
    task automatic push_block(bit is_pt, bit last, int stall);
        rec_t e;
        int   rs = (is_pt && last) ? 0 : 6;
        for (int s = 0; s < stall; s++) begin
            e = '0; e.busy = 1; e.ready = 1; e.sel = 1; e.round = 4'(rs);
            push(e, 0, 1'b0, busy_start());
        end
        e = '0; e.busy = 1; e.ready = 1; e.sel = 1; e.en = 1; e.xd = 1; e.round = 4'(rs);
        e.oc = is_pt; e.xk = is_pt && last;
        push(e, 0, 1'b1, busy_start());
        for (int r = rs + 1; r <= 11; r++) begin
            e = '0; e.busy = 1; e.en = 1; e.sel = 1; e.round = 4'(r);
            e.xl  = (r == 11) && !is_pt && last;
            e.xkf = (r == 11) && is_pt && last;
            push(e, 0, free_valid(), busy_start());
        end
    endtask

    task automatic build(int which, int max_stall, int pt1_stall, int trail);
        rec_t e;
        int nb_ad = (which == 0) ? 1 : 2;
        int nb_pt = (which == 0) ? 3 : 1;
        exp_q.delete(); msk_q.delete(); vld_q.delete(); st_q.delete();
        e = '0;
        push(e, 1, free_valid(), 1'b1);
        for (int r = 0; r < 12; r++) begin
            e = '0; e.busy = 1; e.en = 1; e.round = 4'(r); e.sel = (r != 0); e.xkf = (r == 11);
            push(e, 0, free_valid(), busy_start());
        end
        for (int b = 0; b < nb_ad; b++)
            push_block(1'b0, b == nb_ad - 1, $urandom_range(0, max_stall));
        for (int b = 0; b < nb_pt; b++)
            push_block(1'b1, b == nb_pt - 1, (b == 1 && pt1_stall >= 0) ? pt1_stall : $urandom_range(0, max_stall));
        e = '0; e.busy = 1; e.ot = 1;
        push(e, 1, free_valid(), busy_start());
        e = '0; e.busy = 1; e.done = 1;
        push(e, 1, free_valid(), busy_start());
        for (int t = 0; t < trail; t++) begin
            e = '0;
            push(e, 1, free_valid(), 1'b0);
        end
        // cipher_valid follows each capture by one cycle; tag_valid clears on start, sets after TAG.
        for (int i = 0; i < exp_q.size(); i++) begin
            e = exp_q[i];
            e.cv = (i > 0) ? exp_q[i-1].oc : 1'b0;
            e.tv = (i == 0) ? tv_state[which] : (i == 1) ? 1'b0 : (exp_q[i-1].tv | exp_q[i-1].ot);
            exp_q[i] = e;
        end
    endtask

    task automatic run(int which, string name);
        rec_t o;
        obs_q.delete();
        for (int i = 0; i < exp_q.size(); i++) begin
            drive(which, st_q[i], vld_q[i]);
            @(negedge clk);
            o = (which == 0) ? obs0 : obs1;
            obs_q.push_back(o);
            n_tests++;
            if ((o & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got %h expected %h (mask %h)", name, i, o, exp_q[i], msk_q[i]);
            end
            @(posedge clk); #1;
        end
        drive(which, 1'b0, 1'b0);
        tv_state[which] = exp_q[exp_q.size()-1].tv;
    endtask

    task automatic expect_bit(string name, logic got, logic want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, want);
        end
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (obs0 !== '0 || obs1 !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h / %h expected 0", obs0, obs1);
        end
        resetb = 1'b1;
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0);
        repeat (5) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_tests++;
        if (obs0.round !== 4'd5 || obs0.en !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_init_round: got round %0d en %b expected round 5 en 1", obs0.round, obs0.en);
        end
        #2 resetb = 1'b0;
        #1;
        n_tests++;
        if (obs0 !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_init: got %h expected 0", obs0);
        end
        drive(0, 1'b1, 1'b1);
        @(posedge clk); #1;
        n_tests++;
        if (obs0 !== '0) begin
            n_fail++;
            $display("FAIL reset_held: got %h expected 0", obs0);
        end
        @(negedge clk);
        resetb = 1'b1;
        drive(0, 1'b0, 1'b0);
        tv_state[0] = 1'b0; tv_state[1] = 1'b0;
        @(posedge clk); #1;
        cfg_noise = 0; cfg_all_valid = 1;
        build(0, 0, -1, 1);
        run(0, "restart");
        expect_bit("restart_round0", obs_q[1].round == 4'd0 && obs_q[1].en, 1'b1);
        expect_bit("restart_sel0", obs_q[1].sel, 1'b0);
    endtask

    task automatic test_nominal();
        int oc_count = 0;
        cfg_noise = 0; cfg_all_valid = 1;
        build(0, 0, -1, 1);
        run(0, "nominal");
        for (int i = 0; i < obs_q.size(); i++) if (obs_q[i].oc === 1'b1) oc_count++;
        expect_bit("nom_init_keyfinal_c12", obs_q[12].xkf, 1'b1);
        expect_bit("nom_lsb_c18", obs_q[18].xl, 1'b1);
        expect_bit("nom_cipher_c19_c25_c31", obs_q[19].oc & obs_q[25].oc & obs_q[31].oc, 1'b1);
        expect_bit("nom_cipher_count3", oc_count == 3, 1'b1);
        expect_bit("nom_final_round0_c31", obs_q[31].round == 4'd0 && obs_q[31].xk, 1'b1);
        expect_bit("nom_keyfinal_c42", obs_q[42].xkf, 1'b1);
        expect_bit("nom_tag_c43", obs_q[43].ot, 1'b1);
        expect_bit("nom_done_tv_c44", obs_q[44].done & obs_q[44].tv, 1'b1);
    endtask

    task automatic test_stall();
        cfg_noise = 0; cfg_all_valid = 1;
        build(0, 0, 4, 1);
        run(0, "stall");
        for (int c = 25; c <= 28; c++) begin
            n_tests++;
            if (obs_q[c].en !== 1'b0 || obs_q[c].ready !== 1'b1 || obs_q[c].round !== 4'd6) begin
                n_fail++;
                $display("FAIL stall_hold c%0d: got en %b ready %b round %0d expected 0 1 6",
                         c, obs_q[c].en, obs_q[c].ready, obs_q[c].round);
            end
        end
        expect_bit("stall_xfer_c29", obs_q[29].en & obs_q[29].xd & obs_q[29].oc, 1'b1);
    endtask

    task automatic test_ad2_pt1();
        int xl_count = 0;
        cfg_noise = 0; cfg_all_valid = 1;
        build(1, 0, -1, 1);
        run(1, "ad2_pt1");
        for (int i = 0; i < obs_q.size(); i++) if (obs_q[i].xl === 1'b1) xl_count++;
        expect_bit("ad2_lsb_once_c24", obs_q[24].xl && xl_count == 1, 1'b1);
        expect_bit("pt1_key_round0_c25", obs_q[25].xk && obs_q[25].round == 4'd0, 1'b1);
    endtask

    task automatic test_start_ignored();
        cfg_noise = 0; cfg_all_valid = 1;
        build(0, 0, -1, 1);
        st_q[15] = 1'b1; st_q[16] = 1'b1;
        run(0, "start_in_ad");
        expect_bit("start_ignored_round", obs_q[17].round == 4'd10 && obs_q[17].busy, 1'b1);
    endtask

    task automatic test_valid_init();
        cfg_noise = 0; cfg_all_valid = 0;
        build(0, 0, -1, 1);
        for (int c = 3; c <= 6; c++) vld_q[c] = 1'b1;
        run(0, "valid_in_init");
        expect_bit("valid_init_no_xor", obs_q[5].xd | obs_q[5].ready, 1'b0);
    endtask

    task automatic test_back_to_back();
        cfg_noise = 0; cfg_all_valid = 1;
        build(0, 0, -1, 0);
        run(0, "b2b_first");
        build(0, 0, -1, 1);
        run(0, "b2b_second");
        expect_bit("b2b_tv_before", obs_q[0].tv, 1'b1);
        expect_bit("b2b_tv_cleared", obs_q[1].tv, 1'b0);
        expect_bit("b2b_init_next", obs_q[1].en && obs_q[1].round == 4'd0, 1'b1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            cfg_noise = 1; cfg_all_valid = 0;
            build(k % 2, 3, -1, 1 + $urandom_range(0, 2));
            run(k % 2, "random");
        end
    endtask

    initial begin
        drive(0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0);
        test_reset();
        test_nominal();
        test_stall();
        test_ad2_pt1();
        test_start_ignored();
        test_valid_init();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
